// File: rtl/cift_yollu_fifo_denetleyici.sv
// cift_yollu_fifo_denetleyici
// FIFO controller wrapped around an external dual-port memory. Port 1 of the
// memory is used only for writes and port 2 only for reads. The memory writes
// on the rising edge and captures reads on the falling edge.
//
// Handshake semantics:
//   A push is taken at a rising edge when wr_req is high, the FIFO is not full
//   and flush is low. wr_ack then pulses for exactly one cycle.
//   A pop is taken at a rising edge when rd_req is high, the FIFO is not empty
//   and flush is low. Exactly one cycle later rd_valid pulses with rd_data.
//   The occupancy seen by both decisions is the one from before the edge, so
//   a simultaneous pop never frees room for a push, and a simultaneous push
//   never makes an empty FIFO poppable.
module cift_yollu_fifo_denetleyici #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // push side
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    // pop side
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    // control and status
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf,
    // memory port 1 (write side)
    output logic [ADDR_WIDTH-1:0] m_addr1,
    output logic [DATA_WIDTH-1:0] m_wdata1,
    output logic                  m_cs1,
    output logic                  m_we1,
    output logic                  m_oe1,
    // memory port 2 (read side)
    output logic [ADDR_WIDTH-1:0] m_addr2,
    input  logic [DATA_WIDTH-1:0] m_rdata2,
    output logic                  m_cs2,
    output logic                  m_oe2,
    output logic                  m_we2
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

    // Pointer, occupancy and read-tracking state
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  rd_pend_q, rd_pend_d;

    // Registered user-side outputs
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    // Registered memory strobes
    logic [ADDR_WIDTH-1:0] m_addr1_q, m_addr1_d;
    logic [DATA_WIDTH-1:0] m_wdata1_q, m_wdata1_d;
    logic                  m_cs1_q, m_cs1_d;
    logic                  m_we1_q, m_we1_d;
    logic [ADDR_WIDTH-1:0] m_addr2_q, m_addr2_d;
    logic                  m_cs2_q, m_cs2_d;
    logic                  m_oe2_q, m_oe2_d;

    // Acceptance decisions, based on the occupancy before the edge
    logic full_w;
    logic empty_w;
    logic push_ok;
    logic pop_ok;

    // Status flags decoded from the registered occupancy
    always_comb begin
        full_w  = (count_q == CNT_FULL);
        empty_w = (count_q == '0);
        push_ok = wr_req & ~full_w  & ~flush;
        pop_ok  = rd_req & ~empty_w & ~flush;
    end

    // Pointer and occupancy next-state; flush returns everything to slot 0
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_pend_d = pop_ok;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // User-side outputs: ack, read return and sticky error flags
    always_comb begin
        wr_ack_d   = push_ok;
        // A read issued last cycle was captured by the memory on the falling
        // edge; pick it up now even if flush is asserted this cycle.
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? m_rdata2 : rd_data_q;
        ovf_d      = ovf_q | (wr_req & full_w);
        udf_d      = udf_q | (rd_req & empty_w);
    end

    // Memory strobes: one-cycle pulses, address/data hold when idle
    always_comb begin
        m_addr1_d  = m_addr1_q;
        m_wdata1_d = m_wdata1_q;
        m_cs1_d    = 1'b0;
        m_we1_d    = 1'b0;
        m_addr2_d  = m_addr2_q;
        m_cs2_d    = 1'b0;
        m_oe2_d    = 1'b0;

        if (push_ok) begin
            m_addr1_d  = wr_ptr_q;
            m_wdata1_d = wr_data;
            m_cs1_d    = 1'b1;
            m_we1_d    = 1'b1;
        end
        if (pop_ok) begin
            m_addr2_d = rd_ptr_q;
            m_cs2_d   = 1'b1;
            m_oe2_d   = 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // User-side output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Memory strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr1_q  <= '0;
            m_wdata1_q <= '0;
            m_cs1_q    <= 1'b0;
            m_we1_q    <= 1'b0;
            m_addr2_q  <= '0;
            m_cs2_q    <= 1'b0;
            m_oe2_q    <= 1'b0;
        end else begin
            m_addr1_q  <= m_addr1_d;
            m_wdata1_q <= m_wdata1_d;
            m_cs1_q    <= m_cs1_d;
            m_we1_q    <= m_we1_d;
            m_addr2_q  <= m_addr2_d;
            m_cs2_q    <= m_cs2_d;
            m_oe2_q    <= m_oe2_d;
        end
    end

    // Output wiring; port 1 never reads and port 2 never writes
    always_comb begin
        full     = full_w;
        empty    = empty_w;
        count    = count_q;
        wr_ack   = wr_ack_q;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        ovf      = ovf_q;
        udf      = udf_q;
        m_addr1  = m_addr1_q;
        m_wdata1 = m_wdata1_q;
        m_cs1    = m_cs1_q;
        m_we1    = m_we1_q;
        m_oe1    = 1'b0;
        m_addr2  = m_addr2_q;
        m_cs2    = m_cs2_q;
        m_oe2    = m_oe2_q;
        m_we2    = 1'b0;
    end

endmodule

// File: tb/tb_cift_yollu_fifo_denetleyici.sv
// Bench for cift_yollu_fifo_denetleyici: a behavioural dual-port memory, a
// queue-based FIFO reference model, a step driver and a read-data monitor.
module tb_cift_yollu_fifo_denetleyici;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          flush = 1'b0;
    logic          full, empty, ovf, udf;
    logic [AW:0]   count;
    logic [AW-1:0] m_addr1, m_addr2;
    logic [DW-1:0] m_wdata1, m_rdata2;
    logic          m_cs1, m_we1, m_oe1, m_cs2, m_oe2, m_we2;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    int            wr_ptr_m = 0;
    int            rd_ptr_m = 0;
    bit            ovf_m = 0;
    bit            udf_m = 0;
    bit            prev_pop = 0;

    cift_yollu_fifo_denetleyici #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush(flush), .full(full), .empty(empty), .count(count),
        .ovf(ovf), .udf(udf),
        .m_addr1(m_addr1), .m_wdata1(m_wdata1), .m_cs1(m_cs1), .m_we1(m_we1), .m_oe1(m_oe1),
        .m_addr2(m_addr2), .m_rdata2(m_rdata2), .m_cs2(m_cs2), .m_oe2(m_oe2), .m_we2(m_we2)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural dual-port memory: write on rising edge, read capture on falling edge
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        m_rdata2 = '0;
    end
    always @(posedge clk) if (m_cs1 && m_we1) mem[m_addr1] <= m_wdata1;
    always @(negedge clk) if (m_cs2 && m_oe2) m_rdata2 <= mem[m_addr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every rd_valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_valid_unexpected: got data %0h with nothing expected", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    // one clock cycle of stimulus, with the model predicting the outcome
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        bit full_m, empty_m, push_ok, pop_ok;
        int wp_old, rp_old;
        @(negedge clk);
        wr_req = w; wr_data = d; rd_req = r; flush = f;
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() == 0);
        push_ok = w && !full_m && !f;
        pop_ok  = r && !empty_m && !f;
        if (w && full_m)  ovf_m = 1;
        if (r && empty_m) udf_m = 1;
        wp_old = wr_ptr_m;
        rp_old = rd_ptr_m;
        if (pop_ok) exp_q.push_back(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        if (f) begin
            model_q.delete();
            wr_ptr_m = 0;
            rd_ptr_m = 0;
        end else begin
            if (push_ok) wr_ptr_m = (wr_ptr_m + 1) % DEPTH;
            if (pop_ok)  rd_ptr_m = (rd_ptr_m + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        chk("count", count, model_q.size());
        chk("full", full, model_q.size() == DEPTH);
        chk("empty", empty, model_q.size() == 0);
        chk("wr_ack", wr_ack, push_ok);
        chk("rd_valid", rd_valid, prev_pop);
        chk("ovf", ovf, ovf_m);
        chk("udf", udf, udf_m);
        chk("m_cs1", m_cs1, push_ok);
        chk("m_we1", m_we1, push_ok);
        chk("m_cs2", m_cs2, pop_ok);
        chk("m_oe2", m_oe2, pop_ok);
        chk("m_oe1", m_oe1, 0);
        chk("m_we2", m_we2, 0);
        if (push_ok) begin
            chk("m_addr1", m_addr1, wp_old);
            chk("m_wdata1", m_wdata1, d);
        end
        if (pop_ok) chk("m_addr2", m_addr2, rp_old);
        prev_pop = pop_ok;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_wr_ack"}, wr_ack, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_udf"}, udf, 0);
        chk({tag, "_strobes"}, {m_cs1, m_we1, m_oe1, m_cs2, m_oe2, m_we2}, 0);
        chk({tag, "_m_addr"}, {m_addr1, m_addr2}, 0);
        chk({tag, "_m_wdata1"}, m_wdata1, 0);
    endtask

    // reset asserted in the middle of a clock high phase
    task automatic mid_reset();
        @(negedge clk);
        wr_req = 0; rd_req = 0; flush = 0;
        @(posedge clk);
        #3 rst = 1;
        #1 chk_reset_state("midrst");
        @(negedge clk);
        rst = 0;
        model_q.delete();
        exp_q.delete();
        wr_ptr_m = 0; rd_ptr_m = 0;
        ovf_m = 0; udf_m = 0; prev_pop = 0;
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // power-on reset
        #12 chk_reset_state("rst");
        @(negedge clk);
        rst = 0;

        // ordering
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        step(1, 16'h3333, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // fill and overflow
        for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, 0);
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        step(1, 16'hdead, 0, 0);
        chk("ovf_set", ovf, 1);
        // simultaneous push/pop while full: only the pop is taken
        step(1, 16'hbeef, 1, 0);
        chk("full_pushpop_count", count, 15);
        step(1, 16'h5a5a, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // simultaneous push/pop while empty: only the push is taken
        step(1, 16'h7777, 1, 0);
        chk("empty_pushpop_count", count, 1);
        chk("empty_pushpop_udf", udf, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // wrap-around from pointer origin
        for (int i = 0; i < 16; i++) step(1, DW'($urandom), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++)  step(1, DW'($urandom), 0, 0);
        chk("wrap_count", count, 14);
        chk("wrap_last_addr", m_addr1, 7);
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // simultaneous at count 7, then flush with a pop in flight
        for (int i = 0; i < 7; i++) step(1, DW'($urandom), 0, 0);
        step(1, 16'h0707, 1, 0);
        chk("mid_pushpop_count", count, 7);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("flush_rd_valid", rd_valid, 1);
        chk("flush_count", count, 0);
        step(1, 16'hf00d, 0, 0);
        chk("post_flush_addr", m_addr1, 0);

        // asynchronous reset at count 5
        for (int i = 0; i < 4; i++) step(1, DW'($urandom), 0, 0);
        step(0, 0, 0, 0);
        chk("pre_reset_count", count, 5);
        mid_reset();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), DW'($urandom),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
        end

        // drain and confirm every expected read came back
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
